// File: rtl/fluid_board_soc_mem_crc_pkg.sv
// Shared definitions for the on-chip memory CRC read master.
//   CRC32_POLY / CRC32_INIT / CRC32_XOROUT : IEEE CRC-32, reflected form
//   state_t                                : master control FSM states
//   crc32_word()                           : folds one 32-bit word, byte[7:0] first
package fluid_board_soc_mem_crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // In the reflected form, processing the low byte first is the same as XORing
  // the whole little-endian word in at once and then shifting 32 times.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                             input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fluid_board_soc_crc32_acc.sv
// Registered CRC-32 accumulator: one word folded per enabled cycle.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : reload the seed value (takes priority over en)
//   en           : fold data into the running CRC this cycle
//   data         : 32-bit word to fold
//   crc          : running (not yet inverted) CRC
module fluid_board_soc_crc32_acc
  import fluid_board_soc_mem_crc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= CRC32_INIT;
    end else if (clear) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc32_word(crc, data);
    end
  end

endmodule

// File: rtl/fluid_board_soc_mem_crc_master.sv
// Avalon-MM read master that walks a word range of on-chip memory and returns
// the CRC-32 of the data. Reads are pipelined with at most MAX_PENDING in flight.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   start, abort                 : run request (pulse) / stop request (level)
//   base_addr, word_count        : range, latched on start
//   busy, done, aborted, crc_out : run status and result
//   avm_*                        : Avalon-MM read master port
module fluid_board_soc_mem_crc_master
  import fluid_board_soc_mem_crc_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       crc_out,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int PEND_W = 4;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  issued_q;
  logic [PEND_W-1:0] pending_q;
  logic              stall_q;
  logic              abort_seen_q;
  logic              all_issued;
  logic              issue_ok;
  logic              accept;
  logic              absorb;
  logic              crc_clear;
  logic [31:0]       crc_run;

  assign all_issued = (issued_q == count_q);

  // Abort blocks new requests combinationally so nothing is issued after the
  // cycle it is seen; a request already stalled by waitrequest is held (stall_q)
  // until the slave takes it, as the bus protocol requires.
  assign issue_ok = !all_issued && (pending_q < PEND_W'(MAX_PENDING)) &&
                    !abort && !abort_seen_q;
  assign avm_read       = (state == RUN) && (stall_q || issue_ok);
  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;

  assign accept    = avm_read && !avm_waitrequest;
  // Stray read data with nothing outstanding is dropped.
  assign absorb    = (state == RUN) && avm_readdatavalid && (pending_q != '0);
  assign crc_clear = (state == IDLE) && start;

  fluid_board_soc_crc32_acc u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .en      (absorb),
    .data    (avm_readdata),
    .crc     (crc_run)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      issued_q     <= '0;
      pending_q    <= '0;
      stall_q      <= 1'b0;
      abort_seen_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      crc_out      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            addr_q       <= base_addr;
            count_q      <= word_count;
            issued_q     <= '0;
            pending_q    <= '0;
            stall_q      <= 1'b0;
            abort_seen_q <= 1'b0;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          stall_q <= avm_read && avm_waitrequest;
          if (accept) begin
            addr_q   <= addr_q + ADDR_W'(1);
            issued_q <= issued_q + CNT_W'(1);
          end
          case ({accept, absorb})
            2'b10:   pending_q <= pending_q + PEND_W'(1);
            2'b01:   pending_q <= pending_q - PEND_W'(1);
            default: pending_q <= pending_q;
          endcase
          if (abort) begin
            abort_seen_q <= 1'b1;
          end
          // Exit decision uses registered state only, so the last word's
          // CRC update has settled before FINISH reads it.
          if ((all_issued || abort_seen_q) && (pending_q == '0) && !stall_q) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          crc_out <= crc_run ^ CRC32_XOROUT;
          done    <= 1'b1;
          busy    <= 1'b0;
          aborted <= abort_seen_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fluid_board_soc_mem_crc_master.sv
module tb_fluid_board_soc_mem_crc_master;

  localparam int ADDR_W = 14;
  localparam int CNT_W  = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, done, aborted;
  logic [31:0]       crc_out;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;

  fluid_board_soc_mem_crc_master #(
    .ADDR_W(ADDR_W), .MAX_PENDING(4), .CNT_W(CNT_W)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .abort             (abort),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .crc_out           (crc_out),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-serial reference CRC-32 (reflected IEEE).
  function automatic logic [31:0] crc_fold(input logic [31:0] c_in, input logic [31:0] w);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 4; b++) begin
      c = c ^ {24'h0, w[8*b +: 8]};
      for (int k = 0; k < 8; k++) begin
        if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
        else      c = c >> 1;
      end
    end
    return c;
  endfunction

  // Slave controls (written by the main sequence only).
  int          lat = 1;
  bit          wr_rand = 1'b0;
  logic [31:0] seed = '0;
  int          abort_after = 0;
  int          clr_seq = 0;

  // Slave bookkeeping (written by the slave process only).
  int                clr_seen = 0;
  logic [ADDR_W-1:0] rq_addr[$];
  int                rq_due[$];
  logic [ADDR_W-1:0] acc_addr[$];
  int                cyc = 0, accepts = 0, delivered = 0, peak = 0;
  int                stall_viol = 0, reads_after_abort = 0, read_cycles = 0;
  logic [31:0]       model_crc = 32'hFFFFFFFF;
  bit                acc_flag = 1'b0, prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ seed;
  endfunction

  // Memory slave: acts 2 time units after each rising edge, samples requests at the falling edge.
  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    if (clr_seen != clr_seq) begin
      clr_seen = clr_seq;
      accepts = 0; delivered = 0; peak = 0;
      stall_viol = 0; reads_after_abort = 0; read_cycles = 0;
      model_crc = 32'hFFFFFFFF;
      rq_addr.delete(); rq_due.delete(); acc_addr.delete();
      acc_flag = 1'b0;
    end
    if (acc_flag) begin
      accepts++;
      acc_flag = 1'b0;
    end
    if (avm_readdatavalid) begin
      delivered++;
      model_crc = crc_fold(model_crc, avm_readdata);
    end
    if (accepts - delivered > peak) peak = accepts - delivered;
    abort = (abort_after != 0) && (delivered >= abort_after);
    avm_readdatavalid = 1'b0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = mem_word(rq_addr[0]);
      void'(rq_due.pop_front());
      void'(rq_addr.pop_front());
    end
    avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    if (!reset_n) begin
      rq_addr.delete(); rq_due.delete();
      avm_readdatavalid = 1'b0;
      acc_flag = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!avm_read || avm_address !== prev_addr)) stall_viol++;
      if (abort && avm_read) reads_after_abort++;
      if (avm_read) read_cycles++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      if (avm_read && !avm_waitrequest) begin
        acc_flag = 1'b1;
        rq_addr.push_back(avm_address);
        rq_due.push_back(cyc + lat);
        acc_addr.push_back(avm_address);
      end
    end
  end

  // Start one run and wait (bounded) for done; ncyc counts edges from the start-sampling edge.
  task automatic run(input logic [ADDR_W-1:0] base, input int count, input int lat_i,
                     input bit wr_i, input logic [31:0] seed_i, input int abort_i,
                     output int ncyc, output bit timeout);
    lat = lat_i; wr_rand = wr_i; seed = seed_i; abort_after = abort_i;
    clr_seq++;
    @(posedge clk); #1;
    base_addr = base; word_count = CNT_W'(count); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    ncyc = 0;
    timeout = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      ncyc++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
    check("done_seen", 32'(timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit to;
    logic [ADDR_W-1:0] exp_a;
    logic [31:0] got_a;

    // Reset state
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_crc", crc_out, 32'h0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("byteenable", 32'(avm_byteenable), 32'hF);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // One zero word: known CRC, minimum latency N+3, one-cycle done pulse
    run(14'h0000, 1, 1, 1'b0, 32'h0, 0, n, to);
    check("zero_crc", crc_out, 32'h2144DF1C);
    check("zero_aborted", 32'(aborted), 32'd0);
    check("zero_latency", 32'(n), 32'd4);
    check("zero_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("crc_held", crc_out, 32'h2144DF1C);

    // "abcd"
    run(14'h0000, 1, 1, 1'b0, 32'h64636261, 0, n, to);
    check("abcd_crc", crc_out, 32'hED82CD11);

    // Empty range
    run(14'h0123, 0, 1, 1'b0, 32'h0, 0, n, to);
    check("empty_latency", 32'(n), 32'd2);
    check("empty_crc", crc_out, 32'h0);
    check("empty_reads", 32'(read_cycles), 32'd0);

    // Streaming run, no stalls: latency and CRC
    run(14'h0040, 8, 1, 1'b0, 32'hA5A5_0F0F, 0, n, to);
    check("stream_latency", 32'(n), 32'd11);
    check("stream_crc", crc_out, ~model_crc);

    // Address wrap under random waitrequest
    run(14'h3FFE, 4, 1, 1'b1, 32'h1357_9BDF, 0, n, to);
    check("wrap_count", 32'(acc_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_a = 14'h3FFE + ADDR_W'(i);
      got_a = (i < acc_addr.size()) ? 32'(acc_addr[i]) : 32'hFFFF_FFFF;
      check($sformatf("wrap_addr%0d", i), got_a, 32'(exp_a));
    end
    check("wrap_stall_hold", 32'(stall_viol), 32'd0);
    check("wrap_crc", crc_out, ~model_crc);

    // Slow slave: outstanding reads capped
    run(14'h0200, 20, 8, 1'b0, 32'h0BAD_F00D, 0, n, to);
    check("pend_peak", 32'(peak), 32'd4);
    check("pend_words", 32'(delivered), 32'd20);
    check("pend_crc", crc_out, ~model_crc);

    // Abort once 10 words returned with 3 still in flight
    run(14'h0010, 100, 3, 1'b0, 32'hCAFE_0001, 10, n, to);
    check("abort_accepts", 32'(accepts), 32'd13);
    check("abort_folded", 32'(delivered), 32'd13);
    check("abort_flag", 32'(aborted), 32'd1);
    check("abort_no_reads", 32'(reads_after_abort), 32'd0);
    check("abort_crc", crc_out, ~model_crc);

    // Reset in the middle of a run, then a fresh run
    lat = 2; wr_rand = 1'b0; seed = 32'h1234_ABCD; abort_after = 0;
    clr_seq++;
    @(posedge clk); #1;
    base_addr = 14'h0100; word_count = CNT_W'(50); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_aborted", 32'(aborted), 32'd0);
    check("midrst_crc", crc_out, 32'h0);
    check("midrst_read", 32'(avm_read), 32'd0);
    check("midrst_addr", 32'(avm_address), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run(14'h0300, 2, 1, 1'b0, 32'h5555_AAAA, 0, n, to);
    check("after_rst_latency", 32'(n), 32'd5);
    check("after_rst_crc", crc_out, ~model_crc);
    check("after_rst_aborted", 32'(aborted), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
